// File: rtl/mem_access.sv
// MEM stage: data-memory request/ack transaction, load alignment/sign extension, registered writeback.
// Optional build macro MEM_ALIGN_CHECK_EN adds misaligned LW/SW trapping and the align_err_o output.

`ifndef MEM_NOP_OP
`define MEM_NOP_OP 8'h00
`endif
`ifndef MEM_LB_OP
`define MEM_LB_OP 8'h01
`endif
`ifndef MEM_LW_OP
`define MEM_LW_OP 8'h02
`endif
`ifndef MEM_SB_OP
`define MEM_SB_OP 8'h03
`endif
`ifndef MEM_SW_OP
`define MEM_SW_OP 8'h04
`endif

module mem_access #(
  parameter int OP_W        = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic [OP_W-1:0] mem_op_i,
  input  logic [31:0]     mem_addr_i,
  input  logic [31:0]     mem_data_i,
  input  logic [4:0]      waddr_i,
  input  logic            we_i,
  input  logic [31:0]     wdata_i,
  output logic            stall_o,
  output logic            dreq_o,
  output logic            dwe_o,
  output logic [31:0]     daddr_o,
  output logic [31:0]     dwdata_o,
  output logic [3:0]      dbe_o,
  input  logic            dack_i,
  input  logic [31:0]     drdata_i,
  output logic            valid_o,
  output logic [4:0]      waddr_o,
  output logic            we_o,
  output logic [31:0]     wdata_o,
  output logic            bus_err_o
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic            align_err_o
`endif
);

  localparam logic [OP_W-1:0] OP_LB = OP_W'(`MEM_LB_OP);
  localparam logic [OP_W-1:0] OP_LW = OP_W'(`MEM_LW_OP);
  localparam logic [OP_W-1:0] OP_SB = OP_W'(`MEM_SB_OP);
  localparam logic [OP_W-1:0] OP_SW = OP_W'(`MEM_SW_OP);
  localparam logic [7:0]      CNT_LAST = 8'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  // Byte select for LB (little-endian) with explicit signed extension; LW passes the word through.
  function automatic logic [31:0] load_wdata(input logic is_lb, input logic [1:0] lo,
                                             input logic [31:0] word);
    logic signed [7:0]  b;
    logic signed [31:0] ext;
    b   = word[{lo, 3'b000} +: 8];
    ext = 32'(b);
    return is_lb ? ext : word;
  endfunction

  function automatic logic [3:0] byte_en(input logic is_sb, input logic [1:0] lo);
    return is_sb ? (4'b0001 << lo) : 4'hF;
  endfunction

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [4:0]        waddr_q, waddr_d;
  logic              we_q, we_d;
  logic              dreq_q, dreq_d;
  logic              dwe_q, dwe_d;
  logic [31:0]       daddr_q, daddr_d;
  logic [31:0]       dwdata_q, dwdata_d;
  logic [3:0]        dbe_q, dbe_d;
  logic              valid_q, valid_d;
  logic [4:0]        wb_waddr_q, wb_waddr_d;
  logic              wb_we_q, wb_we_d;
  logic [31:0]       wb_wdata_q, wb_wdata_d;
  logic              bus_err_q, bus_err_d;
  logic              align_err_q, align_err_d;

  logic in_lb, in_lw, in_sb, in_sw, is_mem, in_store, misaligned;
  logic q_lb, q_load;

  assign in_lb    = (mem_op_i == OP_LB);
  assign in_lw    = (mem_op_i == OP_LW);
  assign in_sb    = (mem_op_i == OP_SB);
  assign in_sw    = (mem_op_i == OP_SW);
  assign in_store = in_sb | in_sw;
  assign is_mem   = valid_i & (in_lb | in_lw | in_sb | in_sw);
  assign q_lb     = (op_q == OP_LB);
  assign q_load   = (op_q == OP_LB) | (op_q == OP_LW);

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = (in_lw | in_sw) & (mem_addr_i[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign stall_o = ((state_q == S_IDLE) & is_mem) | (state_q == S_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      addr_lo_q   <= '0;
      waddr_q     <= '0;
      we_q        <= 1'b0;
      dreq_q      <= 1'b0;
      dwe_q       <= 1'b0;
      daddr_q     <= '0;
      dwdata_q    <= '0;
      dbe_q       <= '0;
      valid_q     <= 1'b0;
      wb_waddr_q  <= '0;
      wb_we_q     <= 1'b0;
      wb_wdata_q  <= '0;
      bus_err_q   <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      addr_lo_q   <= addr_lo_d;
      waddr_q     <= waddr_d;
      we_q        <= we_d;
      dreq_q      <= dreq_d;
      dwe_q       <= dwe_d;
      daddr_q     <= daddr_d;
      dwdata_q    <= dwdata_d;
      dbe_q       <= dbe_d;
      valid_q     <= valid_d;
      wb_waddr_q  <= wb_waddr_d;
      wb_we_q     <= wb_we_d;
      wb_wdata_q  <= wb_wdata_d;
      bus_err_q   <= bus_err_d;
      align_err_q <= align_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    addr_lo_d   = addr_lo_q;
    waddr_d     = waddr_q;
    we_d        = we_q;
    dreq_d      = dreq_q;
    dwe_d       = dwe_q;
    daddr_d     = daddr_q;
    dwdata_d    = dwdata_q;
    dbe_d       = dbe_q;
    valid_d     = 1'b0;
    wb_waddr_d  = wb_waddr_q;
    wb_we_d     = wb_we_q;
    wb_wdata_d  = wb_wdata_q;
    bus_err_d   = 1'b0;
    align_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (is_mem) begin
          op_d      = mem_op_i;
          addr_lo_d = mem_addr_i[1:0];
          waddr_d   = waddr_i;
          we_d      = we_i;
          if (misaligned) begin
            // Trapped access: no bus cycle, retire straight through DONE without a write.
            valid_d     = 1'b1;
            wb_waddr_d  = waddr_i;
            wb_we_d     = 1'b0;
            wb_wdata_d  = '0;
            align_err_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            dreq_d   = 1'b1;
            dwe_d    = in_store;
            daddr_d  = {mem_addr_i[31:2], 2'b00};
            dwdata_d = in_sb ? {4{mem_data_i[7:0]}} : (in_sw ? mem_data_i : 32'h0);
            dbe_d    = byte_en(in_sb, mem_addr_i[1:0]);
            cnt_d    = '0;
            state_d  = S_WAIT;
          end
        end else begin
          valid_d    = valid_i;
          wb_waddr_d = waddr_i;
          wb_we_d    = we_i;
          wb_wdata_d = wdata_i;
        end
      end
      S_WAIT: begin
        if (dack_i) begin
          dreq_d     = 1'b0;
          dwe_d      = 1'b0;
          dbe_d      = '0;
          valid_d    = 1'b1;
          wb_waddr_d = waddr_q;
          wb_we_d    = q_load & we_q;
          wb_wdata_d = q_load ? load_wdata(q_lb, addr_lo_q, drdata_i) : 32'h0;
          state_d    = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          dreq_d     = 1'b0;
          dwe_d      = 1'b0;
          dbe_d      = '0;
          valid_d    = 1'b1;
          wb_waddr_d = waddr_q;
          wb_we_d    = 1'b0;
          wb_wdata_d = '0;
          bus_err_d  = 1'b1;
          state_d    = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        // Upstream advances at the end of this cycle; current inputs belong to the retiring op.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dreq_o    = dreq_q;
  assign dwe_o     = dwe_q;
  assign daddr_o   = daddr_q;
  assign dwdata_o  = dwdata_q;
  assign dbe_o     = dbe_q;
  assign valid_o   = valid_q;
  assign waddr_o   = wb_waddr_q;
  assign we_o      = wb_we_q;
  assign wdata_o   = wb_wdata_q;
  assign bus_err_o = bus_err_q;
`ifdef MEM_ALIGN_CHECK_EN
  assign align_err_o = align_err_q;
`else
  logic unused_align;
  assign unused_align = align_err_q;
`endif

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: scripted EX-side stimulus, a bus responder inside the transaction task,
// and a writeback scoreboard drained whenever valid_o is seen.

`ifndef MEM_NOP_OP
`define MEM_NOP_OP 8'h00
`endif
`ifndef MEM_LB_OP
`define MEM_LB_OP 8'h01
`endif
`ifndef MEM_LW_OP
`define MEM_LW_OP 8'h02
`endif
`ifndef MEM_SB_OP
`define MEM_SB_OP 8'h03
`endif
`ifndef MEM_SW_OP
`define MEM_SW_OP 8'h04
`endif

module tb_mem_access;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic [7:0]  mem_op_i = `MEM_NOP_OP;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] mem_data_i = '0;
  logic [4:0]  waddr_i = '0;
  logic        we_i = 1'b0;
  logic [31:0] wdata_i = '0;
  logic        stall_o, dreq_o, dwe_o;
  logic [31:0] daddr_o, dwdata_o;
  logic [3:0]  dbe_o;
  logic        dack_i = 1'b0;
  logic [31:0] drdata_i = '0;
  logic        valid_o, we_o, bus_err_o;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o;
`ifdef MEM_ALIGN_CHECK_EN
  logic        align_err_o;
`endif

  mem_access #(.OP_W(8), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .mem_op_i(mem_op_i),
    .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .waddr_i(waddr_i),
    .we_i(we_i), .wdata_i(wdata_i), .stall_o(stall_o), .dreq_o(dreq_o),
    .dwe_o(dwe_o), .daddr_o(daddr_o), .dwdata_o(dwdata_o), .dbe_o(dbe_o),
    .dack_i(dack_i), .drdata_i(drdata_i), .valid_o(valid_o), .waddr_o(waddr_o),
    .we_o(we_o), .wdata_o(wdata_o), .bus_err_o(bus_err_o)
`ifdef MEM_ALIGN_CHECK_EN
    , .align_err_o(align_err_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  wa;
    logic        we;
    logic [31:0] wd;
    logic        chk_wd;
    logic        err;
    logic        aerr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard drain: every writeback must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && valid_o) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 32'(valid_o), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("wb_waddr", 32'(waddr_o), 32'(mon_e.wa));
        check("wb_we", 32'(we_o), 32'(mon_e.we));
        if (mon_e.chk_wd) check("wb_wdata", wdata_o, mon_e.wd);
        check("wb_bus_err", 32'(bus_err_o), 32'(mon_e.err));
`ifdef MEM_ALIGN_CHECK_EN
        check("wb_align_err", 32'(align_err_o), 32'(mon_e.aerr));
`endif
      end
    end else if (!rst && bus_err_o) begin
      check("stray_bus_err", 32'(bus_err_o), 32'd0);
    end
  end

  task automatic nonmem(input logic v, input logic [4:0] wa, input logic we,
                        input logic [31:0] wd);
    @(negedge clk);
    valid_i = v; mem_op_i = `MEM_NOP_OP; waddr_i = wa; we_i = we; wdata_i = wd;
    #1 check("nonmem_stall", 32'(stall_o), 32'd0);
    if (v) sb.push_back('{wa, we, wd, 1'b1, 1'b0, 1'b0});
  endtask

  // ack_after = WAIT cycle (1-based) in which dack_i is raised; 0 means never.
  task automatic mem_txn(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data,
                         input logic [4:0] wa, input logic we, input logic [31:0] rdata,
                         input int ack_after, input logic [3:0] exp_be, input logic exp_dwe,
                         input logic [31:0] exp_bus_wd, input logic [31:0] exp_wb,
                         input logic exp_we, input logic chk_wd, input logic exp_err);
    int  n;
    bit  done;
    n = 0; done = 0;
    @(negedge clk);
    valid_i = 1'b1; mem_op_i = op; mem_addr_i = addr; mem_data_i = data;
    waddr_i = wa; we_i = we; wdata_i = 32'h5A5A_5A5A; dack_i = 1'b0;
    #1 check("accept_stall", 32'(stall_o), 32'd1);
    sb.push_back('{wa, exp_we, exp_wb, chk_wd, exp_err, 1'b0});
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (!dreq_o) begin
        done = 1;
      end else begin
        n++;
        check("wait_stall", 32'(stall_o), 32'd1);
        check("daddr", daddr_o, {addr[31:2], 2'b00});
        check("dbe", 32'(dbe_o), 32'(exp_be));
        check("dwe", 32'(dwe_o), 32'(exp_dwe));
        if (exp_dwe) check("dwdata", dwdata_o, exp_bus_wd);
        if (n == ack_after) begin
          dack_i = 1'b1; drdata_i = rdata;
        end else begin
          dack_i = 1'b0;
        end
      end
    end
    check("txn_bounded", 32'(done), 32'd1);
    dack_i = 1'b0;
    check("dreq_cycles", 32'(n), exp_err ? 32'(TO) : 32'(ack_after));
    check("done_valid", 32'(valid_o), 32'd1);
    check("done_stall", 32'(stall_o), 32'd0);
    check("done_bus_err", 32'(bus_err_o), 32'(exp_err));
    valid_i = 1'b0; mem_op_i = `MEM_NOP_OP;
  endtask

  function automatic logic [31:0] lb_model(input logic [31:0] w, input int k);
    logic [7:0] b;
    b = w[8*k +: 8];
    return {{24{b[7]}}, b};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    repeat (3) @(negedge clk);
    check("rst_dreq", 32'(dreq_o), 32'd0);
    check("rst_bus", {dwe_o, dbe_o, 27'd0}, 32'd0);
    check("rst_daddr", daddr_o | dwdata_o, 32'd0);
    check("rst_wb", {valid_o, we_o, bus_err_o, waddr_o, 24'd0}, 32'd0);
    check("rst_wdata", wdata_o, 32'd0);
    rst = 1'b0;

    // ALU result passes through with one cycle of latency.
    nonmem(1'b1, 5'd3, 1'b1, 32'h1234_5678);
    @(negedge clk);
    check("add_valid", 32'(valid_o), 32'd1);
    check("add_wdata", wdata_o, 32'h1234_5678);
    check("add_stall", 32'(stall_o), 32'd0);
    valid_i = 1'b0;
    @(negedge clk);
    check("bubble_valid", 32'(valid_o), 32'd0);

    mem_txn(`MEM_LW_OP, 32'h100, 32'h0, 5'd5, 1'b1, 32'hDEAD_BEEF, 2, 4'hF, 1'b0, 32'h0,
            32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0);
    mem_txn(`MEM_LB_OP, 32'h103, 32'h0, 5'd7, 1'b1, 32'h80FF_1122, 1, 4'hF, 1'b0, 32'h0,
            32'hFFFF_FF80, 1'b1, 1'b1, 1'b0);
    mem_txn(`MEM_LB_OP, 32'h101, 32'h0, 5'd8, 1'b1, 32'h80FF_1122, 1, 4'hF, 1'b0, 32'h0,
            32'h0000_0011, 1'b1, 1'b1, 1'b0);
    mem_txn(`MEM_SB_OP, 32'h202, 32'h0000_00AB, 5'd9, 1'b1, 32'h0, 1, 4'b0100, 1'b1,
            32'hABAB_ABAB, 32'h0, 1'b0, 1'b0, 1'b0);
    mem_txn(`MEM_SW_OP, 32'h300, 32'hCAFE_F00D, 5'd10, 1'b1, 32'h0, 3, 4'hF, 1'b1,
            32'hCAFE_F00D, 32'h0, 1'b0, 1'b0, 1'b0);

    // Timeout, then a stray ack while idle.
    mem_txn(`MEM_LW_OP, 32'h400, 32'h0, 5'd11, 1'b1, 32'h0, 0, 4'hF, 1'b0, 32'h0,
            32'h0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    dack_i = 1'b1; drdata_i = 32'h1111_1111;
    @(negedge clk);
    dack_i = 1'b0;
    check("stray_ack_valid", 32'(valid_o), 32'd0);
    check("stray_ack_dreq", 32'(dreq_o), 32'd0);

    // Reset in the second WAIT cycle, with an ack arriving during and after reset.
    @(negedge clk);
    valid_i = 1'b1; mem_op_i = `MEM_LW_OP; mem_addr_i = 32'h100; waddr_i = 5'd12; we_i = 1'b1;
    @(negedge clk);
    check("pre_rst_dreq", 32'(dreq_o), 32'd1);
    @(negedge clk);
    rst = 1'b1; valid_i = 1'b0; mem_op_i = `MEM_NOP_OP; dack_i = 1'b1; drdata_i = 32'h2222_2222;
    @(negedge clk);
    check("mid_rst_dreq", 32'(dreq_o), 32'd0);
    check("mid_rst_bus", {dwe_o, dbe_o, 27'd0}, 32'd0);
    check("mid_rst_wb", {valid_o, we_o, bus_err_o, waddr_o, 24'd0}, 32'd0);
    check("mid_rst_wdata", wdata_o | daddr_o, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    dack_i = 1'b0;
    check("post_rst_valid", 32'(valid_o), 32'd0);
    check("post_rst_dreq", 32'(dreq_o), 32'd0);
    mem_txn(`MEM_LW_OP, 32'h104, 32'h0, 5'd13, 1'b1, 32'h0BAD_F00D, 1, 4'hF, 1'b0, 32'h0,
            32'h0BAD_F00D, 1'b1, 1'b1, 1'b0);

    // Back-to-back ALU results and a bubble.
    for (int i = 0; i < 6; i++) nonmem(1'b1, 5'(i + 1), 1'(i % 2), $urandom);
    nonmem(1'b0, 5'd0, 1'b0, 32'h0);

    // LB at every byte lane against an independent model.
    for (int k = 0; k < 4; k++) begin
      w = $urandom;
      w[8*k + 7] = k[0];
      mem_txn(`MEM_LB_OP, 32'h500 + 32'(k), 32'h0, 5'(20 + k), 1'b1, w, 1 + k, 4'hF, 1'b0,
              32'h0, lb_model(w, k), 1'b1, 1'b1, 1'b0);
    end

`ifdef MEM_ALIGN_CHECK_EN
    @(negedge clk);
    valid_i = 1'b1; mem_op_i = `MEM_LW_OP; mem_addr_i = 32'h102; waddr_i = 5'd14; we_i = 1'b1;
    #1 check("align_accept_stall", 32'(stall_o), 32'd1);
    sb.push_back('{5'd14, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1});
    @(negedge clk);
    check("align_no_dreq", 32'(dreq_o), 32'd0);
    check("align_valid", 32'(valid_o), 32'd1);
    check("align_err", 32'(align_err_o), 32'd1);
    check("align_done_stall", 32'(stall_o), 32'd0);
    valid_i = 1'b0; mem_op_i = `MEM_NOP_OP;
    @(negedge clk);
    check("align_err_pulse", 32'(align_err_o), 32'd0);
`else
    mem_txn(`MEM_LW_OP, 32'h102, 32'h0, 5'd14, 1'b1, 32'h7777_0001, 1, 4'hF, 1'b0, 32'h0,
            32'h7777_0001, 1'b1, 1'b1, 1'b0);
`endif

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
